// File: rtl/clk_edge_monitor.sv
// Samples a slow divided clock in the clk domain, emits one-cycle rise/fall enables,
// measures rise-to-rise period and high time, and flags a missing slow clock.
module clk_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slow_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_cnt,
   output logic             period_valid,
   output logic             lost,
   output logic [1:0]       state_dbg
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOST = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;
   logic                   rise_pulse_q, rise_pulse_d;
   logic                   fall_pulse_q, fall_pulse_d;
   logic                   period_valid_q, period_valid_d;
   logic                   lost_q, lost_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
   logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
   logic                   s, rise, fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      sync_d         = {sync_q[SYNC_STAGES-2:0], slow_in};
      s              = sync_q[SYNC_STAGES-1];
      s_d_d          = s;
      rise           = s & ~s_d_q;
      fall           = ~s & s_d_q;
      rise_pulse_d   = rise;
      fall_pulse_d   = fall;
      state_d        = state_q;
      period_d       = period_q;
      high_cnt_d     = high_cnt_q;
      run_cnt_d      = run_cnt_q;
      hi_cnt_d       = hi_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      period_valid_d = 1'b0;
      lost_d         = lost_q;

      case (state_q)
         ST_IDLE, ST_LOST: begin
            // Falls are ignored until a rise re-arms measurement.
            if (rise) begin
               state_d    = ST_RUN;
               run_cnt_d  = CNT_W'(1);
               hi_cnt_d   = CNT_W'(1);
               idle_cnt_d = '0;
               lost_d     = 1'b0;
            end
         end
         ST_RUN: begin
            if (rise) begin
               period_d       = run_cnt_q;
               period_valid_d = 1'b1;
               run_cnt_d      = CNT_W'(1);
               hi_cnt_d       = CNT_W'(1);
               idle_cnt_d     = '0;
            end else begin
               run_cnt_d = sat_inc(run_cnt_q);
               if (fall) begin
                  high_cnt_d = hi_cnt_q;
                  idle_cnt_d = '0;
               end else begin
                  // hi_cnt only advances while the synchronized level is high.
                  if (s_d_q) hi_cnt_d = sat_inc(hi_cnt_q);
                  if (idle_cnt_q == IDLE_LAST) begin
                     state_d = ST_LOST;
                     lost_d  = 1'b1;
                  end else begin
                     idle_cnt_d = idle_cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         sync_q         <= '0;
         s_d_q          <= 1'b0;
         rise_pulse_q   <= 1'b0;
         fall_pulse_q   <= 1'b0;
         period_valid_q <= 1'b0;
         lost_q         <= 1'b0;
         period_q       <= '0;
         high_cnt_q     <= '0;
         run_cnt_q      <= '0;
         hi_cnt_q       <= '0;
         idle_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         s_d_q          <= s_d_d;
         rise_pulse_q   <= rise_pulse_d;
         fall_pulse_q   <= fall_pulse_d;
         period_valid_q <= period_valid_d;
         lost_q         <= lost_d;
         period_q       <= period_d;
         high_cnt_q     <= high_cnt_d;
         run_cnt_q      <= run_cnt_d;
         hi_cnt_q       <= hi_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
      end
   end

   assign rise_pulse   = rise_pulse_q;
   assign fall_pulse   = fall_pulse_q;
   assign period       = period_q;
   assign high_cnt     = high_cnt_q;
   assign period_valid = period_valid_q;
   assign lost         = lost_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Bench for clk_edge_monitor: event-level model of the slow clock checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_clk_edge_monitor;

   localparam int SYNC  = 2;
   localparam int CNT_W = 4;
   localparam int TMO   = 20;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int M_IDLE = 0, M_RUN = 1, M_LOST = 2;

   logic             clk;
   logic             rst_n;
   logic             slow_in;
   logic             rise_pulse, fall_pulse, period_valid, lost;
   logic [CNT_W-1:0] period, high_cnt;
   logic [1:0]       state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   int pv_seen  = 0;

   clk_edge_monitor #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .slow_in(slow_in),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .period(period), .high_cnt(high_cnt),
      .period_valid(period_valid), .lost(lost), .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the slow clock is a sample history; outputs derive from edge times.
   bit hist[0:8191];
   int edge_n   = 0;
   int last_rst = -1;
   int last_rise = 0, last_evt = 0, m_mode = M_IDLE;
   int exp_rise = 0, exp_fall = 0, exp_period = 0, exp_high = 0, exp_pv = 0, exp_lost = 0;
   bit model_ok = 0;

   function automatic int eff(input int k);
      if (k < 0 || k <= last_rst) return 0;
      return int'(hist[k]);
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   initial begin
      int s_now, s_old, r, f;
      forever begin
         @(posedge clk);
         if (edge_n < 8192) hist[edge_n] = slow_in;
         if (!rst_n) begin
            last_rst = edge_n; m_mode = M_IDLE;
            exp_rise = 0; exp_fall = 0; exp_period = 0; exp_high = 0; exp_pv = 0; exp_lost = 0;
         end else begin
            s_now = eff(edge_n - SYNC);
            s_old = eff(edge_n - SYNC - 1);
            r = (s_now == 1 && s_old == 0) ? 1 : 0;
            f = (s_now == 0 && s_old == 1) ? 1 : 0;
            exp_rise = r; exp_fall = f; exp_pv = 0;
            if (m_mode == M_RUN) begin
               if (r == 1) begin
                  exp_period = sat(edge_n - last_rise); exp_pv = 1;
                  last_rise = edge_n; last_evt = edge_n;
               end else if (f == 1) begin
                  exp_high = sat(edge_n - last_rise); last_evt = edge_n;
               end else if (edge_n - last_evt >= TMO) begin
                  m_mode = M_LOST; exp_lost = 1;
               end
            end else if (r == 1) begin
               m_mode = M_RUN; last_rise = edge_n; last_evt = edge_n; exp_lost = 0;
            end
         end
         edge_n++;
         model_ok = 1;
      end
   end

   // compare process
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("rise_pulse",   int'(rise_pulse),   exp_rise);
            check("fall_pulse",   int'(fall_pulse),   exp_fall);
            check("period",       int'(period),       exp_period);
            check("high_cnt",     int'(high_cnt),     exp_high);
            check("period_valid", int'(period_valid), exp_pv);
            check("lost",         int'(lost),         exp_lost);
            check("state",        int'(state_dbg),    m_mode);
            if (period_valid === 1'b1) pv_seen++;
         end
      end
   end

   // driver tasks
   task automatic drive_div(input int hi, input int lo, input int n);
      for (int p = 0; p < n; p++) begin
         slow_in = 1'b1;
         repeat (hi) @(negedge clk);
         slow_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic check_rise_latency(input string name);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("%s_rise_c%0d", name, k), int'(rise_pulse), (k == 3) ? 1 : 0);
         check($sformatf("%s_pv_c%0d", name, k), int'(period_valid), 0);
      end
   endtask

   initial begin
      int cnt, got, base;
      rst_n = 1'b0;
      slow_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rise", int'(rise_pulse), 0);
      check("reset_period", int'(period), 0);
      check("reset_lost", int'(lost), 0);
      check("reset_state", int'(state_dbg), M_IDLE);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // T2: latency of the first rise, no period_valid
      slow_in = 1'b1;
      check_rise_latency("t2");
      slow_in = 1'b0;
      repeat (6) @(negedge clk);

      // T1: divide-by-4
      drive_div(2, 2, 6);
      check("t1_period", int'(period), 4);
      check("t1_high", int'(high_cnt), 2);
      check("t1_state", int'(state_dbg), M_RUN);

      // T3: loss after TMO edge-free cycles, then recovery
      cnt = 0; got = 0;
      for (int k = 0; k < 80 && got == 0; k++) begin
         @(negedge clk);
         if (fall_pulse) cnt = 0; else cnt++;
         if (lost) got = 1;
      end
      check("t3_lost_seen", got, 1);
      check("t3_lost_delay", cnt, TMO);
      drive_div(3, 3, 3);
      check("t3_lost_cleared", int'(lost), 0);
      check("t3_period", int'(period), 6);
      check("t3_high", int'(high_cnt), 3);

      // T4: saturation at 4 bits, then an in-range period
      drive_div(10, 10, 3);
      check("t4_period_sat", int'(period), 15);
      check("t4_high", int'(high_cnt), 10);
      drive_div(6, 6, 3);
      check("t4_period_12", int'(period), 12);
      check("t4_high_6", int'(high_cnt), 6);

      // T5: one-cycle reset mid-run
      drive_div(2, 2, 2);
      rst_n = 1'b0;
      slow_in = 1'b0;
      @(negedge clk);
      check("t5_rise", int'(rise_pulse), 0);
      check("t5_fall", int'(fall_pulse), 0);
      check("t5_period", int'(period), 0);
      check("t5_high", int'(high_cnt), 0);
      check("t5_pv", int'(period_valid), 0);
      check("t5_lost", int'(lost), 0);
      check("t5_state", int'(state_dbg), M_IDLE);
      rst_n = 1'b1;
      base = pv_seen;
      drive_div(2, 2, 4);
      repeat (4) @(negedge clk);
      check("t5_pv_count", pv_seen - base, 3);
      check("t5_period", int'(period), 4);

      // T6: slow_in high through reset release
      rst_n = 1'b0;
      slow_in = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_rise_latency("t6");
      repeat (25) @(negedge clk);
      check("t6_lost", int'(lost), 1);
      slow_in = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_state_lost", int'(state_dbg), M_LOST);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
